// File: rtl/gpr_pkg.sv
// Shared constants and types for the general-purpose register file.
// Holds the default geometry plus the word and register-address types.
package gpr_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int NRD_DEF    = 2;
   localparam int NWR_DEF    = 2;
   localparam int AW_DEF     = $clog2(DEPTH_DEF);

   typedef logic [WORD_W_DEF-1:0] word_t;
   typedef logic [AW_DEF-1:0]     raddr_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit tracker: issue sets, writes clear, NRD combinational lookups.
// Ports: clk, rstn, iss_en/iss_addr, wr_en/wr_addr, rd_addr -> rd_busy.
// GPR_FILE_BYPASS_EN: lookups see this cycle's set/clear.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int NRD   = NRD_DEF,
   parameter  int NWR   = NWR_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    iss_en,
   input  logic [AW-1:0]           iss_addr,
   input  logic [NWR-1:0]          wr_en,
   input  logic [NWR-1:0][AW-1:0]  wr_addr,
   input  logic [NRD-1:0][AW-1:0]  rd_addr,
   output logic [NRD-1:0]          rd_busy
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Clears first so a same-cycle issue wins; r0 never busy.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j]) busy_d[wr_addr[j]] = 1'b0;
      end
      if (iss_en) busy_d[iss_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
`ifdef GPR_FILE_BYPASS_EN
         rd_busy[i] = busy_d[rd_addr[i]];
`else
         rd_busy[i] = busy_q[rd_addr[i]];
`endif
      end
   end

endmodule

// File: rtl/gpr_file.sv
// Multi-ported register file with busy scoreboard and registered reads.
// Ports: clk, rstn; rd_en/rd_addr -> rd_data/rd_busy (1-cycle latency);
// wr_en/wr_addr/wr_data; iss_en/iss_addr. r0 is hardwired to zero.
// GPR_FILE_BYPASS_EN: reads return same-cycle writes and busy updates.
module gpr_file
   import gpr_pkg::*;
#(
   parameter  int WORD_W = WORD_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int NRD    = NRD_DEF,
   parameter  int NWR    = NWR_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NRD-1:0]             rd_en,
   input  logic [NRD-1:0][AW-1:0]     rd_addr,
   output logic [NRD-1:0][WORD_W-1:0] rd_data,
   output logic [NRD-1:0]             rd_busy,
   input  logic [NWR-1:0]             wr_en,
   input  logic [NWR-1:0][AW-1:0]     wr_addr,
   input  logic [NWR-1:0][WORD_W-1:0] wr_data,
   input  logic                       iss_en,
   input  logic [AW-1:0]              iss_addr
);

   logic [DEPTH-1:0][WORD_W-1:0] regs_q;
   logic [DEPTH-1:0][WORD_W-1:0] regs_d;
   logic [NRD-1:0][WORD_W-1:0]   rd_data_q;
   logic [NRD-1:0][WORD_W-1:0]   rd_data_d;
   logic [NRD-1:0]               rd_busy_q;
   logic [NRD-1:0]               rd_busy_d;
   logic [NRD-1:0]               sb_busy;

   // Ascending port order: highest index wins on collision.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j]) regs_d[wr_addr[j]] = wr_data[j];
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   gpr_scoreboard #(
      .DEPTH (DEPTH),
      .NRD   (NRD),
      .NWR   (NWR)
   ) u_sb (
      .clk      (clk),
      .rstn     (rstn),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (sb_busy)
   );

   always_comb begin
      rd_data_d = rd_data_q;
      rd_busy_d = rd_busy_q;
      for (int i = 0; i < NRD; i++) begin
         if (rd_en[i]) begin
`ifdef GPR_FILE_BYPASS_EN
            rd_data_d[i] = regs_d[rd_addr[i]];
`else
            rd_data_d[i] = regs_q[rd_addr[i]];
`endif
            rd_busy_d[i] = sb_busy[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
         rd_busy_q <= rd_busy_d;
      end
   end

   assign rd_data = rd_data_q;
   assign rd_busy = rd_busy_q;

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have parameter WORD_W, default 32: data word width.
REQ-002 SHALL have parameter DEPTH, default 32: register count, power of two, minimum 2.
REQ-003 SHALL have parameter NRD, default 2: read port count.
REQ-004 SHALL have parameter NWR, default 2: write port count.
REQ-005 SHALL derive localparam AW = $clog2(DEPTH).
REQ-006 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rd_en, input, [NRD]: per-port read strobe.
REQ-009 SHALL have port rd_addr, input, [NRD][AW]: read address.
REQ-010 SHALL have port rd_data, output, [NRD][WORD_W]: registered read data.
REQ-011 SHALL have port rd_busy, output, [NRD]: registered scoreboard bit of the addressed register.
REQ-012 SHALL have port wr_en, input, [NWR]: write strobe.
REQ-013 SHALL have port wr_addr, input, [NWR][AW]: write address.
REQ-014 SHALL have port wr_data, input, [NWR][WORD_W]: write data.
REQ-015 SHALL have port iss_en, input, 1 bit: issue strobe; marks a destination pending.
REQ-016 SHALL have port iss_addr, input, [AW]: issue destination.

Function
REQ-017 SHALL, on each clk edge with rd_en[i]=1, load rd_data[i] and rd_busy[i] from rd_addr[i]; read latency 1 cycle.
REQ-018 SHALL hold rd_data[i] and rd_busy[i] while rd_en[i]=0.
REQ-019 SHALL read register 0 as 0 with busy 0; writes and issues to address 0 are discarded.
REQ-020 SHALL commit each wr_en[j] write at the clk edge; on an address collision, the highest port index j wins.
REQ-021 SHALL clear the busy bit of each written address at the clk edge.
REQ-022 SHALL set busy[iss_addr] at the clk edge when iss_en=1; set overrides a same-cycle clear of the same address.
REQ-023 SHALL treat busy as state only; writes to busy registers are accepted.
REQ-024 SHALL allow any number of read ports to address the same register concurrently.

Reset
REQ-025 SHALL, while rstn=0, force all registers, busy bits, rd_data and rd_busy to 0 asynchronously.
REQ-026 SHALL ignore all strobes during reset; the first operation is taken at the first clk edge after rstn rises.

Configuration
REQ-027 SHALL, with GPR_FILE_BYPASS_EN defined, return in rd_data a same-cycle write to rd_addr (highest j on collision) and return rd_busy reflecting that cycle's clear and issue.
REQ-028 SHALL, without GPR_FILE_BYPASS_EN, return the pre-edge register and busy values for a same-cycle write.

Structure
REQ-029 SHALL place the default WORD_W/DEPTH/NRD/NWR constants and the typedefs word_t and raddr_t in package gpr_pkg.
REQ-030 SHALL implement busy tracking in sub-module gpr_scoreboard, which takes the issue and write-clear inputs and provides NRD read lookups.

Verification
REQ-031 SHALL cover: reset, then read all 32 registers -> rd_data=0 and rd_busy=0 on every port.
REQ-032 SHALL cover: write r5=0xDEADBEEF, then read r5 on both ports next cycle -> 0xDEADBEEF one cycle later.
REQ-033 SHALL cover: write r0=0x1234 -> a read of r0 returns 0.
REQ-034 SHALL cover: same cycle, wr port0 r7=0x11 and port1 r7=0x22 -> r7 reads 0x22.
REQ-035 SHALL cover: iss r9, read r9 -> busy=1; write r9=0x55 with iss r9 in the same cycle -> busy stays 1 and data reads 0x55.
REQ-036 SHALL cover: write r3=0xA5 and read r3 in the same cycle -> 0xA5 with the macro defined, the old value without it.
